// File: rtl/adma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adma_pkg
// Brief    : Shared types and widths for the ADMA data-mover blocks.
// Revision : 1.0 - initial release
// ============================================================================
package adma_pkg;

   localparam int ADMA_MST_ID_W  = 5;
   localparam int ADMA_ATX_LEN_W = 8;
   localparam int ADMA_INFO_W    = ADMA_MST_ID_W + ADMA_ATX_LEN_W;

   typedef struct packed {
      logic [ADMA_MST_ID_W-1:0]  id;
      logic [ADMA_ATX_LEN_W-1:0] len;
   } adma_info_t;

endpackage
`default_nettype wire

// File: rtl/adma_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : adma_sync_fifo
// Brief    : Show-ahead synchronous FIFO with registered full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module adma_sync_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_full,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_empty
);

   // DEPTH must be a power of two so the pointers wrap naturally
   localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]     C_FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [AW:0]       w_count_nxt;
   logic              r_full;
   logic              r_empty;
   logic              w_push;
   logic              w_pop;

   assign w_push  = i_push & ~r_full;
   assign w_pop   = i_pop  & ~r_empty;
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_rdata = r_mem[r_rd_ptr];

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == C_FULL_CNT);
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule
`default_nettype wire

// File: rtl/adma_dm_dst_axis.sv
`default_nettype none
// ============================================================================
// Module   : adma_dm_dst_axis
// Brief    : DMA destination data mover emitting each write transaction as
//            one AXI-Stream packet, with per-transaction completions.
// Revision : 1.0 - initial release
// ============================================================================
module adma_dm_dst_axis
   import adma_pkg::*;
#(
   parameter int DMA_CHN_NUM      = 4,
   parameter int ATX_DST_DATA_W   = 256,
   parameter int ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
   parameter int DST_TDEST_W      = 2,
   parameter int MST_ID_W         = ADMA_MST_ID_W,
   parameter int ATX_LEN_W        = ADMA_ATX_LEN_W,
   parameter int ATX_NUM_OSTD     = DMA_CHN_NUM
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [MST_ID_W-1:0]             atx_awid,
   input  logic [ATX_LEN_W-1:0]            atx_awlen,
   input  logic                            atx_vld,
   output logic                            atx_rdy,
   input  logic [ATX_DST_DATA_W-1:0]       atx_wdata,
   input  logic [ATX_DST_BYTE_AMT-1:0]     atx_wstrb,
   input  logic                            atx_wdata_vld,
   output logic                            atx_wdata_rdy,
   output logic [MST_ID_W-1:0]             atx_bid,
   output logic                            atx_bvld,
   input  logic                            atx_brdy,
   input  logic [DMA_CHN_NUM*MST_ID_W-1:0] atx_id,
   output logic [DMA_CHN_NUM-1:0]          atx_dst_err,
   output logic [MST_ID_W-1:0]             m_tid_o,
   output logic [DST_TDEST_W-1:0]          m_tdest_o,
   output logic [ATX_DST_DATA_W-1:0]       m_tdata_o,
   output logic [ATX_DST_BYTE_AMT-1:0]     m_tkeep_o,
   output logic [ATX_DST_BYTE_AMT-1:0]     m_tstrb_o,
   output logic                            m_tlast_o,
   output logic                            m_tvalid_o,
   input  logic                            m_tready_i
);

   adma_info_t                w_info_in;
   adma_info_t                w_head;
   logic                      w_info_full;
   logic                      w_info_empty;
   logic                      w_info_push;
   logic                      w_cpl_full;
   logic                      w_cpl_empty;
   logic [MST_ID_W-1:0]       w_cpl_id;
   logic                      w_is_last;
   logic                      w_out_load;
   logic                      w_wdata_rdy;
   logic                      w_beat;
   logic                      w_last_beat;
   logic [DST_TDEST_W-1:0]    w_tdest;

   logic [ATX_LEN_W-1:0]      r_cnt;
   logic                      r_tvalid;
   logic [ATX_DST_DATA_W-1:0] r_tdata;
   logic [ATX_DST_BYTE_AMT-1:0] r_tstrb;
   logic [ATX_DST_BYTE_AMT-1:0] r_tkeep;
   logic [MST_ID_W-1:0]       r_tid;
   logic [DST_TDEST_W-1:0]    r_tdest;
   logic                      r_tlast;

   assign w_info_in.id  = atx_awid;
   assign w_info_in.len = atx_awlen;
   assign w_info_push   = atx_vld & ~w_info_full;
   assign atx_rdy       = ~w_info_full;

   adma_sync_fifo #(
      .DEPTH  (ATX_NUM_OSTD),
      .DATA_W (ADMA_INFO_W)
   ) u_info_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .i_push  (w_info_push),
      .i_wdata (w_info_in),
      .o_full  (w_info_full),
      .i_pop   (w_last_beat),
      .o_rdata (w_head),
      .o_empty (w_info_empty)
   );

   // Compare before increment, so len = all-ones never wraps the counter
   assign w_is_last   = (r_cnt == w_head.len);
   assign w_out_load  = ~r_tvalid | m_tready_i;
   assign w_wdata_rdy = ~w_info_empty & w_out_load & ~(w_is_last & w_cpl_full);
   assign w_beat      = atx_wdata_vld & w_wdata_rdy;
   assign w_last_beat = w_beat & w_is_last;
   assign atx_wdata_rdy = w_wdata_rdy;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_cnt <= '0;
      end else if (w_beat) begin
         r_cnt <= w_is_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Lowest matching channel wins: scan downward so lower indices overwrite
   always_comb begin
      w_tdest = '0;
      for (int c = DMA_CHN_NUM - 1; c >= 0; c--) begin
         if (atx_id[c*MST_ID_W +: MST_ID_W] == w_head.id) begin
            w_tdest = DST_TDEST_W'(c);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tstrb  <= '0;
         r_tkeep  <= '0;
         r_tid    <= '0;
         r_tdest  <= '0;
         r_tlast  <= 1'b0;
      end else if (w_out_load) begin
         r_tvalid <= w_beat;
         if (w_beat) begin
            r_tdata <= atx_wdata;
            r_tstrb <= atx_wstrb;
            r_tkeep <= '1;
            r_tid   <= w_head.id;
            r_tdest <= w_tdest;
            r_tlast <= w_is_last;
         end
      end
   end

   assign m_tvalid_o = r_tvalid;
   assign m_tdata_o  = r_tdata;
   assign m_tstrb_o  = r_tstrb;
   assign m_tkeep_o  = r_tkeep;
   assign m_tid_o    = r_tid;
   assign m_tdest_o  = r_tdest;
   assign m_tlast_o  = r_tlast;

   adma_sync_fifo #(
      .DEPTH  (ATX_NUM_OSTD),
      .DATA_W (MST_ID_W)
   ) u_cpl_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .i_push  (w_last_beat),
      .i_wdata (w_head.id),
      .o_full  (w_cpl_full),
      .i_pop   (atx_brdy),
      .o_rdata (w_cpl_id),
      .o_empty (w_cpl_empty)
   );

   // Storage is not reset, so mask the head entry while nothing is pending
   assign atx_bvld    = ~w_cpl_empty;
   assign atx_bid     = w_cpl_empty ? '0 : w_cpl_id;
   assign atx_dst_err = '0;

endmodule
`default_nettype wire
